sequence_generator: RTL and testbench

Serial pattern transmitter: the source end of the serial bit-sequence path whose sink is the sequence detector. It latches a right-aligned pattern word on a start request and shifts it out MSB-first, one bit per clock, optionally repeating with idle gap bits between repetitions. Alongside the bit stream it provides framing strobes (`out_valid`, `last_bit`, `done`), so it can drive the detector directly, either as an on-chip stimulus source or in loopback benches.

---
 rtl/sequence_generator.sv | 159 +++++++++++++++
 tb/tb_sequence_generator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter. Latches a right-aligned
// pattern word on start and shifts it out MSB-first, one bit per clock.
// Optional repetition with idle gap cycles between repetitions, plus
// out_valid / last_bit / done framing strobes. All outputs are registered.
module sequence_generator #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [GAP_W-1:0]   gap,
  output logic               out_seq,
  output logic               out_valid,
  output logic               last_bit,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CNT_W-1:0]     reps_q, reps_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     rep_q, rep_d;
  logic [GAP_W-1:0]     gcnt_q, gcnt_d;

  logic out_seq_q, out_seq_d;
  logic out_valid_q, out_valid_d;
  logic last_bit_q, last_bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [LEN_W-1:0] len_clamp;
  logic [CNT_W-1:0] rep_inc;
  logic             more_reps;

  // Next-state logic: start acceptance, bit/gap/repetition sequencing, abort
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gcnt_d  = gcnt_q;

    len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    // Repetition counter saturates so infinite mode never wraps to 0
    rep_inc   = (rep_q == '1) ? rep_q : rep_q + CNT_W'(1);
    more_reps = (reps_q == '0) || (rep_q < reps_q);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !abort) begin
          pat_d  = pattern;
          len_d  = len_clamp;
          reps_d = reps;
          gap_d  = gap;
          rep_d  = CNT_W'(1);
          if (len_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
            idx_d   = len_clamp - LEN_W'(1);
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - LEN_W'(1);
        end else if (more_reps) begin
          if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end else begin
            idx_d = len_q - LEN_W'(1);
            rep_d = rep_inc;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d = S_SHIFT;
          idx_d   = len_q - LEN_W'(1);
          rep_d   = rep_inc;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency after start.
    out_seq_d   = (state_d == S_SHIFT) && |(pat_d & (MAX_LEN'(1) << idx_d));
    out_valid_d = (state_d == S_SHIFT);
    last_bit_d  = (state_d == S_SHIFT) && (idx_d == '0);
    busy_d      = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      gcnt_q      <= '0;
      out_seq_q   <= 1'b0;
      out_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      reps_q      <= reps_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      gcnt_q      <= gcnt_d;
      out_seq_q   <= out_seq_d;
      out_valid_q <= out_valid_d;
      last_bit_q  <= last_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_seq   = out_seq_q;
  assign out_valid = out_valid_q;
  assign last_bit  = last_bit_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: the driver pushes the expected
// per-cycle output tuple for every active cycle; the monitor pops and
// compares on each falling edge where the DUT shows busy/out_valid/done.
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [7:0]  reps = '0;
  logic [3:0]  gap = '0;
  logic        out_seq, out_valid, last_bit, busy, done;

  sequence_generator #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .reps(reps), .gap(gap),
    .out_seq(out_seq), .out_valid(out_valid), .last_bit(last_bit),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {out_seq, out_valid, last_bit, busy, done}
  typedef logic [4:0] obs_t;
  obs_t exp_q[$];
  obs_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic obs_t now_obs();
    return {out_seq, out_valid, last_bit, busy, done};
  endfunction

  // Monitor: compare every active output cycle against the scoreboard
  always @(negedge clk) begin
    if (out_valid || busy || done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(now_obs()), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("stream", 32'(now_obs()), 32'(mon_e));
      end
    end
  end

  // Push the first cnt bits of an n-bit pattern, MSB first
  task automatic push_bits(input logic [15:0] p, input int n, input int cnt);
    for (int i = n - 1; i >= n - cnt; i--)
      exp_q.push_back({p[i], 1'b1, (i == 0), 1'b1, 1'b0});
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(5'b00010);
  endtask

  task automatic push_done();
    exp_q.push_back(5'b00001);
  endtask

  // Called at #1 after an edge; start is sampled on the next edge
  task automatic issue(input logic [15:0] p, input logic [4:0] l,
                       input logic [7:0] r, input logic [3:0] g);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for scoreboard to empty and DUT to go quiet; records done cycle
  task automatic drain(input int budget);
    int c = 0;
    done_at = -1;
    while (1) begin
      if (done && done_at < 0) done_at = c;
      if (exp_q.size() == 0 && !busy && !done) break;
      if (c >= budget) begin
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(now_obs()), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single repetition: 0110, last_bit on 4th bit, done after 4 busy cycles
    push_bits(16'h0006, 4, 4); push_done();
    issue(16'h0006, 5'd4, 8'd1, 4'd0);
    chk("A_latency", {30'd0, busy, out_valid}, 32'd3);
    drain(50);
    chk("A_done_time", 32'(done_at), 32'd4);
    repeat (2) @(posedge clk); #1;

    // Three repetitions with 2-cycle gaps, no trailing gap
    push_bits(16'h0006, 4, 4); push_gap(2);
    push_bits(16'h0006, 4, 4); push_gap(2);
    push_bits(16'h0006, 4, 4); push_done();
    issue(16'h0006, 5'd4, 8'd3, 4'd2);
    drain(100);
    chk("B_done_time", 32'(done_at), 32'd16);
    repeat (2) @(posedge clk); #1;

    // len=0: immediate done, no bits regardless of reps
    push_done();
    issue(16'h0006, 5'd0, 8'd5, 4'd0);
    chk("len0_latency", {29'd0, busy, done, out_valid}, 32'd2);
    drain(20);
    chk("len0_done_time", 32'(done_at), 32'd0);
    repeat (2) @(posedge clk); #1;

    // len=20 clamps to 16
    push_bits(16'hB38F, 16, 16); push_done();
    issue(16'hB38F, 5'd20, 8'd1, 4'd0);
    drain(60);
    chk("clamp_done_time", 32'(done_at), 32'd16);
    repeat (2) @(posedge clk); #1;

    // start while busy and pattern changes mid-transfer are ignored
    push_bits(16'h00A5, 8, 8); push_gap(1);
    push_bits(16'h00A5, 8, 8); push_done();
    issue(16'h00A5, 5'd8, 8'd2, 4'd1);
    pattern = 16'hFFFF; len = 5'd3; reps = 8'd1; gap = 4'd0; start = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    start = 1'b0; pattern = 16'h0000;
    drain(60);
    repeat (2) @(posedge clk); #1;

    // Infinite mode, abort on 2nd bit of 5th repetition
    for (int r = 0; r < 4; r++) push_bits(16'h0006, 4, 4);
    push_bits(16'h0006, 4, 2);
    issue(16'h0006, 5'd4, 8'd0, 4'd0);
    repeat (17) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outputs", 32'(now_obs()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    drain(10);

    // abort and start together in IDLE: nothing starts
    pattern = 16'h0006; len = 5'd4; reps = 8'd1; gap = 4'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'(now_obs()), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-transmission, then a clean restart
    push_bits(16'h0006, 4, 2);
    issue(16'h0006, 5'd4, 8'd1, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("reset_mid", 32'(now_obs()), 32'd0);
    @(posedge clk); #1;
    chk("reset_mid_quiet", 32'(now_obs()), 32'd0);
    push_bits(16'h0006, 4, 4); push_done();
    issue(16'h0006, 5'd4, 8'd1, 4'd0);
    drain(30);
    chk("restart_done_time", 32'(done_at), 32'd4);
    repeat (2) @(posedge clk); #1;

    // 12-bit pattern, chained start in the DONE cycle: back-to-back
    push_bits(16'h0366, 12, 12); push_done();
    push_bits(16'h0366, 12, 12); push_done();
    issue(16'h0366, 5'd12, 8'd1, 4'd0);
    c = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk("chain_done_seen", {31'd0, done}, 32'd1);
    issue(16'h0366, 5'd12, 8'd1, 4'd0);
    chk("chain_latency", {30'd0, busy, out_valid}, 32'd3);
    drain(60);
    chk("chain_done_time", 32'(done_at), 32'd12);
    repeat (3) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
